addsub_seq: RTL and testbench
=============================

# addsub_seq

Parametrised multi-cycle adder/subtractor: the successor to the gate-level 4-bit ripple adder. Operands up to WIDTH bits are processed CHUNK bits per clock through a single CHUNK-bit ripple slice, which trades latency for area. A start/busy/done handshake makes it usable as an arithmetic unit behind a controller. Results are registered, and the block adds subtract mode and signed-overflow detection.

## Interface
- WIDTH, 16, operand/result width; WIDTH must be an integer multiple of CHUNK.
- CHUNK, 4, bits summed per clock (1 ≤ CHUNK ≤ WIDTH); NCH = WIDTH/CHUNK.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising clk when state is IDLE or DONE.
- sub  input  1  0 = add, 1 = subtract; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in (add) / borrow-in (subtract); sampled with start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse when result is valid.
- s  output  WIDTH  result.
- cout  output  1  raw carry out of bit WIDTH-1.
- ovf  output  1  signed (two's-complement) overflow.

## Operation
- Function:
  - sub=0: {cout,s} = a + b + cin.
  - sub=1: {cout,s} = a + ~b + ~cin, i.e. a − b − cin.
  - In subtract mode, cout=1 means no borrow.
- Registers:
  - Operand shift registers A and B (B stored pre-inverted when sub=1).
  - Running carry register.
  - Partial-sum shift register.
  - Chunk counter, ceil(log2(NCH+1)) bits.
- States: IDLE, RUN, DONE (binary encoding is fine).
- IDLE:
  - busy=0, done=0.
  - start=1 → latch a, b^{WIDTH{sub}} and cin^sub; clear the counter; go to RUN.
- RUN:
  - Each edge adds the low CHUNK bits of A and B plus the carry.
  - The chunk sum shifts into the top of the partial-sum register; A and B shift right by CHUNK.
  - The carry updates and the counter increments.
  - When the counter reaches NCH−1 on an edge (i.e. the last chunk), go to DONE instead of staying in RUN.
  - start is ignored in RUN.
- Last chunk:
  - ovf = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1).
  - s, cout and ovf are loaded into the output registers on the same edge.
- DONE:
  - Lasts exactly one cycle with done=1, busy=0.
  - start=1 → behaves as in IDLE (back-to-back accept) and goes to RUN.
  - Otherwise → IDLE.
- s, cout and ovf hold their values until the next result is loaded. They do not change while a new operation is running.
- The chunk adder is plain ripple logic; no lookahead is required.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, s=0, cout=0, ovf=0; internal registers cleared.
- Reset mid-RUN aborts the operation. No done is produced and outputs are zero after reset.
- Latency: start is sampled at edge E0; RUN occupies edges E1..E_NCH; done=1 during the cycle after E_NCH.
  - Start-to-done is NCH+1 edges (WIDTH=16, CHUNK=4 → 5).
- busy is high from after E0 until E_NCH. busy and done are never high together.
- Throughput: one result per NCH+1 cycles with back-to-back starts.
- Degenerate case CHUNK=WIDTH: NCH=1, so RUN lasts one edge and start-to-done is 2 edges.
- Inputs a, b, sub and cin may change freely after the start edge.

## Test plan
- WIDTH=16, CHUNK=4, sub=0, a=0x1234, b=0x4321, cin=0 → done on the 5th edge after start; s=0x5555, cout=0, ovf=0; busy high for exactly 4 cycles.
- Add a=0xFFFF, b=0x0001, cin=0 → s=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → s=0x8000, cout=0, ovf=1.
- Subtract a=0x0005, b=0x0007, cin=0 → s=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 → s=0x7FFF, cout=1, ovf=1. Then a=0x0010, b=0x0003, cin=1 → s=0x000C, cout=1.
- Handshake edge cases:
  - start held high through RUN → ignored; the second operation begins only at the DONE cycle.
  - Back-to-back starts → done pulses exactly 5 cycles apart.
  - s holds its old value during the second RUN.
- Assert rst_n low on the 2nd RUN edge of a=0xFFFF+b=0xFFFF → all outputs 0 immediately; no done pulse. After release, a new start completes normally with s=0xFFFE, cout=1.
- Parameter sweep:
  - CHUNK ∈ {1, 2, 4, 8, 16}, and WIDTH=8 with CHUNK ∈ {1, 8}.
  - 1000 random add/sub operations each, checked against a behavioural model of (s, cout, ovf).
  - Latency is NCH+1 in every case (e.g. 17 for CHUNK=1, 2 for CHUNK=16).

Source files
------------

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle adder/subtractor built around a single CHUNK-bit
// ripple slice. A WIDTH-bit operation is processed CHUNK bits per clock,
// least-significant chunk first. The result is ready NCH+1 edges after start.
//
// Parameters:
//   WIDTH  operand/result width (an integer multiple of CHUNK)
//   CHUNK  bits summed per clock (1..WIDTH)
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled in IDLE or DONE (ignored while busy)
//   sub    0 = a+b+cin, 1 = a-b-cin (sampled with start)
//   a, b   operands (sampled with start)
//   cin    carry-in / borrow-in (sampled with start)
//   busy   high while the operation is running
//   done   one-cycle pulse when s/cout/ovf hold a new result
//   s      registered result
//   cout   raw carry out of the MSB (in subtract mode, 1 = no borrow)
//   ovf    two's-complement overflow
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = $clog2(NCH + 1);
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] psum_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;

  logic             accept;
  logic             last;
  logic [CHUNK:0]   c;
  logic [CHUNK-1:0] chunk_sum;
  logic [WIDTH-1:0] psum_shift;

  // A new operation can be taken whenever the slice is not in use.
  assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last   = (cnt_reg == LAST);

  // Single CHUNK-bit ripple slice working on the low chunk of the operands.
  assign c[0] = carry_reg;
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_ripple
    assign chunk_sum[gi] = a_reg[gi] ^ b_reg[gi] ^ c[gi];
    assign c[gi+1]       = (a_reg[gi] & b_reg[gi]) | (c[gi] & (a_reg[gi] ^ b_reg[gi]));
  end

  // The new chunk enters at the top, so after NCH shifts the least-significant
  // chunk has walked down to bit 0. Written with shifts so that CHUNK == WIDTH
  // needs no special case.
  assign psum_shift = (psum_reg >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      psum_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + ~cin, so B and the carry are inverted once here.
      a_reg     <= a;
      b_reg     <= b ^ {WIDTH{sub}};
      carry_reg <= cin ^ sub;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_reg >> CHUNK;
      b_reg     <= b_reg >> CHUNK;
      psum_reg  <= psum_shift;
      carry_reg <= c[CHUNK];
      cnt_reg   <= cnt_reg + 1'b1;
      if (last) begin
        // On the last chunk the slice's top bit is the word's MSB, so the
        // carry into and out of it give the signed overflow.
        s    <= psum_shift;
        cout <= c[CHUNK];
        ovf  <= c[CHUNK] ^ c[CHUNK-1];
      end
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq. Configuration 0 (WIDTH=16, CHUNK=4) gets directed
// vectors with literal expectations; configurations 1..7 sweep CHUNK and WIDTH
// with random add/sub traffic. Every configuration has a cycle-level model
// (arithmetic result plus start-edge bookkeeping) checked on each falling edge.
module tb_addsub_seq;

  localparam int NCFG = 8;

  function automatic int cfg_w(input int i);
    return (i >= 6) ? 8 : 16;
  endfunction

  function automatic int cfg_c(input int i);
    case (i)
      0: return 4;
      1: return 1;
      2: return 2;
      3: return 4;
      4: return 8;
      5: return 16;
      6: return 1;
      default: return 8;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fin_n  = 0;

  task automatic chk(input int cfg, input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %h, expected %h", cfg, nm, act, exp);
    end
  endtask

  // Reference result {ovf, cout, s} from plain integer arithmetic.
  function automatic logic [17:0] ref_op(input int w, input logic sb, input logic [15:0] x,
                                         input logic [15:0] y, input logic ci);
    longint m, ux, uy, sx, sy, u, sv;
    logic   r_o, r_c;
    m  = longint'(1) << w;
    ux = longint'(x);
    uy = longint'(y);
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    if (!sb) begin
      u  = ux + uy + longint'(ci);
      sv = sx + sy + longint'(ci);
    end else begin
      u  = ux - uy - longint'(ci) + m;
      sv = sx - sy - longint'(ci);
    end
    r_o = (sv < -(m / 2)) || (sv >= m / 2);
    r_c = (u >= m);
    return {r_o, r_c, 16'(u % m)};
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int W   = cfg_w(gi);
    localparam int C   = cfg_c(gi);
    localparam int NCH = W / C;

    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] s;

    addsub_seq #(.WIDTH(W), .CHUNK(C)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .sub  (sub),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .busy (busy),
      .done (done),
      .s    (s),
      .cout (cout),
      .ovf  (ovf)
    );

    // Model: e0 is the edge number at which the current operation was
    // accepted; busy covers edges e0..e0+NCH-1, the result lands on e0+NCH.
    int           edge_n;
    int           e0;
    logic [W-1:0] exp_s, pend_s;
    logic         exp_cout, exp_ovf, pend_cout, pend_ovf;
    logic [17:0]  ref_r;
    logic         exp_busy, exp_done;

    assign ref_r    = ref_op(W, sub, 16'(a), 16'(b), cin);
    assign exp_busy = (e0 >= 0) && (edge_n - e0 < NCH);
    assign exp_done = (e0 >= 0) && (edge_n - e0 == NCH);

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        edge_n    <= 0;
        e0        <= -1;
        exp_s     <= '0;
        exp_cout  <= 1'b0;
        exp_ovf   <= 1'b0;
        pend_s    <= '0;
        pend_cout <= 1'b0;
        pend_ovf  <= 1'b0;
      end else begin
        edge_n <= edge_n + 1;
        if (exp_busy && (edge_n - e0 == NCH - 1)) begin
          exp_s    <= pend_s;
          exp_cout <= pend_cout;
          exp_ovf  <= pend_ovf;
        end
        if (start && !exp_busy) begin
          e0        <= edge_n + 1;
          pend_s    <= ref_r[W-1:0];
          pend_cout <= ref_r[16];
          pend_ovf  <= ref_r[17];
        end
      end
    end

    initial forever begin
      @(negedge clk);
      chk(gi, "busy", 16'(busy), 16'(exp_busy));
      chk(gi, "done", 16'(done), 16'(exp_done));
      chk(gi, "s",    16'(s),    16'(exp_s));
      chk(gi, "cout", 16'(cout), 16'(exp_cout));
      chk(gi, "ovf",  16'(ovf),  16'(exp_ovf));
    end

    // Called on a falling edge; operands are scrambled after the start edge.
    task automatic issue(input logic sb, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      start = 1'b1;
      sub   = sb;
      a     = x;
      b     = y;
      cin   = ci;
      @(negedge clk);
      start = 1'b0;
      a     = ~x;
      b     = '0;
      sub   = ~sb;
      cin   = ~ci;
    endtask

    task automatic wait_done(output int n, output int nb);
      n  = 0;
      nb = 0;
      do begin
        @(negedge clk);
        n++;
        if (busy) nb++;
      end while (!done && n < 40);
    endtask

    if (gi == 0) begin : g_dir
      task automatic dir_op(input logic sb, input logic [15:0] x, input logic [15:0] y, input logic ci,
                            input logic [15:0] es, input logic ec, input logic eo, input string nm);
        int n, nb, nb0;
        issue(sb, x, y, ci);
        nb0 = busy ? 1 : 0;
        wait_done(n, nb);
        chk(0, {nm, " latency"}, 16'(n + 1), 16'd5);
        chk(0, {nm, " busy cycles"}, 16'(nb0 + nb), 16'd4);
        chk(0, {nm, " s"}, 16'(s), es);
        chk(0, {nm, " cout"}, 16'(cout), 16'(ec));
        chk(0, {nm, " ovf"}, 16'(ovf), 16'(eo));
      endtask

      initial begin
        int n, nb;
        repeat (2) @(negedge clk);
        chk(0, "reset s/cout/ovf/busy/done", {11'd0, s[4:0] | 5'(s >> 5) | 5'(s >> 10) | 5'(s >> 15)} | 16'({cout, ovf, busy, done}), 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        dir_op(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "add basic");
        @(negedge clk);
        dir_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add carry");
        dir_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add ovf");
        dir_op(1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, "sub borrow");
        dir_op(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, "sub ovf");
        dir_op(1'b1, 16'h0010, 16'h0003, 1'b1, 16'h000C, 1'b1, 1'b0, "sub cin");

        // start held high through RUN: the second operand set is taken at DONE.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; cin = 1'b0; a = 16'h0100; b = 16'h0200;
        @(negedge clk);
        a = 16'h1000; b = 16'h0001;
        wait_done(n, nb);
        chk(0, "held first latency", 16'(n + 1), 16'd5);
        chk(0, "held first s", 16'(s), 16'h0300);
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        chk(0, "held second busy", 16'(busy), 16'd1);
        repeat (3) begin
          @(negedge clk);
          chk(0, "s holds during run", 16'(s), 16'h0300);
        end
        wait_done(n, nb);
        chk(0, "held done spacing", 16'(n + 4), 16'd5);
        chk(0, "held second s", 16'(s), 16'h1001);

        // Back-to-back start issued in the DONE cycle.
        dir_op(1'b0, 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0, "back to back");

        // Asynchronous reset on the second RUN edge aborts the operation.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; cin = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk(0, "abort s", 16'(s), 16'h0000);
        chk(0, "abort flags", 16'({cout, ovf, busy, done}), 16'h0000);
        repeat (3) begin
          @(negedge clk);
          chk(0, "abort no done", 16'(done), 16'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        dir_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, "after reset");
        @(negedge clk);
        fin_n++;
      end
    end else begin : g_rnd
      function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
          0: return '0;
          1: return '1;
          2: return {1'b1, {(W-1){1'b0}}};
          3: return {1'b0, {(W-1){1'b1}}};
          default: return W'($urandom);
        endcase
      endfunction

      initial begin
        int n, nb;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
          issue(1'($urandom_range(0, 1)), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
          wait_done(n, nb);
          chk(gi, "latency", 16'(n + 1), 16'(NCH + 1));
          if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        fin_n++;
      end
    end
  end

  initial begin
    fork
      wait (fin_n == NCFG);
      repeat (60000) @(posedge clk);
    join_any
    checks++;
    if (fin_n != NCFG) begin
      errors++;
      $display("FAIL timeout: finished configs %0d, expected %0d", fin_n, NCFG);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
